// File: rtl/spi_ctrl_regfile.sv
// SPI slave control-register bank: pins are oversampled in the clk domain and
// decoded into {rw, addr[6:0]} commands followed by DATA_W-bit burst words.
module spi_ctrl_regfile #(
    parameter int                N_REGS      = 8,
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sclk,
    input  logic                       sdi,
    input  logic                       cs_n,
    output logic                       sdo,
    output logic [N_REGS*DATA_W-1:0]   regs,
    output logic [N_REGS-1:0]          wr_strobe,
    output logic                       frame_err,
    output logic                       busy
);

    localparam int                AW       = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam int                SH_W     = (DATA_W > 8) ? DATA_W : 8;
    localparam logic [7:0]        N_REGS_8 = 8'(N_REGS);
    localparam logic [5:0]        LAST_BIT = 6'(DATA_W - 1);
    localparam logic [N_REGS-1:0] ONE_HOT0 = N_REGS'(1);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t                  state, state_n;
    logic [SYNC_STAGES-1:0]  sclk_sync, sdi_sync, cs_sync;
    logic                    sclk_q;
    logic                    sclk_s, sdi_s, cs_s, sclk_rise, sclk_fall;
    logic                    armed;
    logic [5:0]              cnt, cnt_n;
    logic [SH_W-2:0]         sh_in, sh_in_n;
    logic [SH_W-1:0]         sh_next;
    logic [6:0]              addr, addr_n, addr_wrap;
    logic [7:0]              addr_inc;
    logic                    rw, rw_n;
    logic [DATA_W-1:0]       sh_out, sh_out_n;
    logic                    sdo_n, err_n, wr_en;
    logic [AW-1:0]           wr_idx;
    logic [DATA_W-1:0]       wr_data;
    logic [DATA_W-1:0]       mem [N_REGS];

    function automatic logic in_range(input logic [6:0] a);
        return ({1'b0, a} < N_REGS_8);
    endfunction

    function automatic logic [DATA_W-1:0] rd_word(input logic [6:0] a);
        if (in_range(a))
            return mem[a[AW-1:0]];
        return '0;
    endfunction

    // Pin synchronisers; sclk edges come from the last two synced samples
    always_ff @(posedge clk) begin
        sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
        sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
        cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
        sclk_q    <= sclk_sync[SYNC_STAGES-1];
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign sh_next   = {sh_in, sdi_s};
    assign addr_inc  = {1'b0, addr} + 8'd1;
    assign addr_wrap = 7'(addr_inc % N_REGS_8);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        sh_in_n  = sh_in;
        addr_n   = addr;
        rw_n     = rw;
        sh_out_n = sh_out;
        sdo_n    = sdo;
        err_n    = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = '0;
        wr_data  = '0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                sdo_n = 1'b0;
                if (armed && !cs_s)
                    state_n = CMD;
            end
            CMD: begin
                if (sclk_rise) begin
                    sh_in_n = sh_next[SH_W-2:0];
                    if (cnt == 6'd7) begin
                        cnt_n   = '0;
                        rw_n    = sh_next[7];
                        addr_n  = sh_next[6:0];
                        state_n = DATA;
                        if (!sh_next[7]) begin
                            sh_out_n = rd_word(sh_next[6:0]);
                            err_n    = !in_range(sh_next[6:0]);
                        end
                    end else begin
                        cnt_n = cnt + 6'd1;
                    end
                end
            end
            DATA: begin
                if (sclk_rise) begin
                    sh_in_n = sh_next[SH_W-2:0];
                    if (cnt == LAST_BIT) begin
                        cnt_n  = '0;
                        addr_n = addr_wrap;
                        if (rw) begin
                            if (in_range(addr)) begin
                                wr_en   = 1'b1;
                                wr_idx  = addr[AW-1:0];
                                wr_data = sh_next[DATA_W-1:0];
                            end else begin
                                err_n = 1'b1;
                            end
                        end else begin
                            sh_out_n = rd_word(addr_wrap);
                            err_n    = !in_range(addr_wrap);
                        end
                    end else begin
                        cnt_n = cnt + 6'd1;
                    end
                end else if (sclk_fall && !rw) begin
                    sdo_n    = sh_out[DATA_W-1];
                    sh_out_n = sh_out << 1;
                end
            end
            default: state_n = IDLE;
        endcase
        // A same-cycle sclk rise is already folded in, so a just-completed word commits cleanly
        if (state != IDLE && cs_s) begin
            state_n = IDLE;
            sdo_n   = 1'b0;
            if (cnt_n != '0)
                err_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sdo       <= 1'b0;
            wr_strobe <= '0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            armed     <= 1'b0;
            for (int k = 0; k < N_REGS; k++)
                mem[k] <= RESET_VAL;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sdo       <= sdo_n;
            wr_strobe <= wr_en ? (ONE_HOT0 << wr_idx) : '0;
            frame_err <= err_n;
            busy      <= ~cs_s;
            armed     <= armed | cs_s;
            if (wr_en)
                mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        sh_in  <= sh_in_n;
        addr   <= addr_n;
        rw     <= rw_n;
        sh_out <= sh_out_n;
    end

    for (genvar k = 0; k < N_REGS; k++) begin : g_regs
        assign regs[k*DATA_W +: DATA_W] = mem[k];
    end

endmodule

// File: tb/tb_spi_ctrl_regfile.sv
// Directed bench for spi_ctrl_regfile: bit-banged SPI frames with hand-computed
// register images, strobe/error pulse counts and read-back words.
module tb_spi_ctrl_regfile;

    logic        clk = 1'b0;
    logic        reset, sclk, sdi, cs_n;
    logic        sdo, frame_err, busy;
    logic [63:0] regs;
    logic [7:0]  wr_strobe;

    int          checks = 0;
    int          errors = 0;
    int          strobe_cycles = 0;
    int          err_cycles = 0;
    logic [7:0]  last_strobe_val = '0;
    time         last_strobe_t = 0;
    time         last_rise_t = 0;
    logic [7:0]  exp_regs [8];
    logic [7:0]  got, dummy;
    int          s0, e0;

    spi_ctrl_regfile #(.N_REGS(8), .DATA_W(8), .SYNC_STAGES(2), .RESET_VAL(8'h00)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .sdi(sdi), .cs_n(cs_n),
        .sdo(sdo), .regs(regs), .wr_strobe(wr_strobe), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe != 8'h00) begin
            strobe_cycles++;
            last_strobe_val = wr_strobe;
            last_strobe_t   = $time;
        end
        if (frame_err)
            err_cycles++;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_image();
        logic [63:0] f;
        for (int k = 0; k < 8; k++)
            f[k*8 +: 8] = exp_regs[k];
        return f;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic sampled);
        sdi = b;
        tick(4);
        sampled = sdo;
        sclk = 1'b1;
        last_rise_t = $time;
        tick(4);
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, output logic [7:0] rx);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(v[i], b);
            rx[i] = b;
        end
    endtask

    task automatic cs_lo();
        cs_n = 1'b0;
        tick(4);
    endtask

    task automatic cs_hi();
        tick(4);
        cs_n = 1'b1;
        tick(6);
    endtask

    initial begin
        reset = 1'b1; sclk = 1'b0; sdi = 1'b0; cs_n = 1'b1;
        for (int k = 0; k < 8; k++) exp_regs[k] = 8'h00;
        tick(5);
        check("reset_regs", regs, 64'h0);
        check("reset_sdo", sdo, 1'b0);
        check("reset_strobe", wr_strobe, 8'h00);
        check("reset_err", frame_err, 1'b0);
        check("reset_busy", busy, 1'b0);
        reset = 1'b0;
        tick(4);

        // Single write, including commit latency relative to the last pin rise
        s0 = strobe_cycles;
        cs_lo();
        tick(2);
        check("busy_in_frame", busy, 1'b1);
        send_byte(8'h83, dummy);
        send_byte(8'hA5, dummy);
        check("t1_latency", 64'(last_strobe_t - last_rise_t), 64'd30);
        check("t1_strobe_val", last_strobe_val, 8'b0000_1000);
        check("t1_strobe_width", strobe_cycles - s0, 1);
        cs_hi();
        exp_regs[3] = 8'hA5;
        check("t1_regs", regs, exp_image());
        check("busy_idle", busy, 1'b0);

        // Burst write wrapping past the last register
        s0 = strobe_cycles; e0 = err_cycles;
        cs_lo();
        send_byte(8'h86, dummy);
        send_byte(8'h11, dummy);
        send_byte(8'h22, dummy);
        send_byte(8'h33, dummy);
        cs_hi();
        exp_regs[6] = 8'h11; exp_regs[7] = 8'h22; exp_regs[0] = 8'h33;
        check("t2_regs", regs, exp_image());
        check("t2_strobes", strobe_cycles - s0, 3);
        check("t2_errs", err_cycles - e0, 0);

        // Preload then read back MSB first
        cs_lo(); send_byte(8'h82, dummy); send_byte(8'h5C, dummy); cs_hi();
        exp_regs[2] = 8'h5C;
        check("t3_preload", regs, exp_image());
        cs_lo();
        send_byte(8'h02, dummy);
        send_byte(8'h00, got);
        check("t3_read_bits", got, 8'h5C);
        cs_hi();
        check("t3_sdo_idle", sdo, 1'b0);

        // Burst read from reg 7 wraps to reg 0
        cs_lo();
        send_byte(8'h07, dummy);
        send_byte(8'h00, got);
        check("burst_rd_w0", got, 8'h22);
        send_byte(8'h00, got);
        check("burst_rd_w1", got, 8'h33);
        cs_hi();

        // Out-of-range write and read
        s0 = strobe_cycles; e0 = err_cycles;
        cs_lo(); send_byte(8'h8A, dummy); send_byte(8'hFF, dummy); cs_hi();
        check("t4_regs", regs, exp_image());
        check("t4_strobes", strobe_cycles - s0, 0);
        check("t4_err", err_cycles - e0, 1);
        e0 = err_cycles;
        cs_lo(); send_byte(8'h0A, dummy); send_byte(8'h00, got); cs_hi();
        check("oor_read_data", got, 8'h00);
        check("oor_read_err", err_cycles - e0, 1);

        // Partial frame aborted by cs_n, then a good write
        s0 = strobe_cycles; e0 = err_cycles;
        cs_lo();
        send_byte(8'h81, dummy);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, dummy[0]);
        cs_hi();
        check("t5_regs", regs, exp_image());
        check("t5_err", err_cycles - e0, 1);
        check("t5_strobes", strobe_cycles - s0, 0);
        cs_lo(); send_byte(8'h81, dummy); send_byte(8'h3C, dummy); cs_hi();
        exp_regs[1] = 8'h3C;
        check("t5_rewrite", regs, exp_image());

        // Reset mid-frame; remainder of the frame must be ignored
        cs_lo();
        send_byte(8'h84, dummy);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, dummy[0]);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) exp_regs[k] = 8'h00;
        check("t6_regs_reset", regs, exp_image());
        s0 = strobe_cycles; e0 = err_cycles;
        for (int i = 0; i < 4; i++) spi_bit(1'b0, dummy[0]);
        send_byte(8'h77, dummy);
        cs_hi();
        check("t6_no_strobe", strobe_cycles - s0, 0);
        check("t6_no_err", err_cycles - e0, 0);
        check("t6_regs_after", regs, exp_image());
        cs_lo(); send_byte(8'h85, dummy); send_byte(8'h99, dummy); cs_hi();
        exp_regs[5] = 8'h99;
        check("t6_new_frame", regs, exp_image());
        check("t6_new_strobe", strobe_cycles - s0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
